// File: rtl/uart_rx_frame_decoder.sv
// UART receive frame decoder: extracts data bits, checks parity/stop bits and buffers results in a show-ahead FIFO.
// Optional build macro UART_RX_DROP_ERR_FRAME_EN discards frames with parity or framing errors instead of storing them.
module uart_rx_frame_decoder #(
    parameter int DEPTH     = 16,
    parameter int RX_THRESH = 1
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       frame_valid_i,
    input  logic [11:0]                frame_i,
    input  logic [3:0]                 number_data_receive,
    input  logic                       parity_bit_mode,
    input  logic                       parity_odd_i,
    input  logic                       stop_bit_twice,
    input  logic                       flush_i,
    input  logic                       rd_en_i,
    output logic [7:0]                 rd_data_o,
    output logic                       rd_perr_o,
    output logic                       rd_ferr_o,
    output logic                       rd_valid_o,
    output logic [$clog2(DEPTH):0]     count_o,
    output logic                       overrun_o,
    output logic                       rx_irq_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT   = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] THRESH_CNT = CNT_W'(RX_THRESH);

    // Frame decode (combinational, from the raw frame and the current configuration)
    logic [3:0] data_len;
    logic [3:0] par_pos;
    logic [3:0] stop_pos;
    logic [3:0] stop2_pos;
    logic [7:0] dec_data;
    logic       dec_perr;
    logic       dec_ferr;
    logic       unused_start_bit;

    assign unused_start_bit = frame_i[0];

    always_comb begin
        data_len = 4'd5;
        case (number_data_receive)
            4'd6:    data_len = 4'd6;
            4'd7:    data_len = 4'd7;
            4'd8:    data_len = 4'd8;
            default: data_len = 4'd5;
        endcase
        par_pos   = data_len + 4'd1;
        stop_pos  = par_pos + {3'b000, parity_bit_mode};
        stop2_pos = stop_pos + 4'd1;
        // Mask keeps only the N data bits, so the stored byte is already zero-extended.
        dec_data  = frame_i[8:1] & (8'hFF >> (4'd8 - data_len));
        dec_perr  = parity_bit_mode & ((^dec_data ^ frame_i[par_pos]) != parity_odd_i);
        dec_ferr  = ~frame_i[stop_pos] | (stop_bit_twice & ~frame_i[stop2_pos]);
    end

    // Stage 1: entry = {ferr, perr, data}
    logic       s1_valid;
    logic [9:0] s1_entry;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            s1_valid <= 1'b0;
            s1_entry <= '0;
        end else if (flush_i) begin
            s1_valid <= 1'b0;
        end else begin
            s1_valid <= frame_valid_i;
            if (frame_valid_i) begin
                s1_entry <= {dec_ferr, dec_perr, dec_data};
            end
        end
    end

    // Stage 2: FIFO write side
    logic             s1_push_req;
    logic [9:0]       mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             fifo_full;
    logic             fifo_empty;
    logic             do_push;
    logic             do_pop;
    logic             drop_push;
    logic             overrun;
    logic             rx_irq;

`ifdef UART_RX_DROP_ERR_FRAME_EN
    assign s1_push_req = s1_valid & ~s1_entry[9] & ~s1_entry[8];
`else
    assign s1_push_req = s1_valid;
`endif

    assign fifo_full  = (count == FULL_CNT);
    assign fifo_empty = (count == '0);
    // Read side: rd_valid_o flags a valid head; the head is consumed at the clock edge
    // where rd_en_i is high, and rd_en_i while rd_valid_o is low is ignored.
    assign do_pop     = rd_en_i & ~fifo_empty;
    assign do_push    = s1_push_req & (~fifo_full | rd_en_i);
    assign drop_push  = s1_push_req & fifo_full & ~rd_en_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            overrun <= 1'b0;
        end else if (flush_i) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            overrun <= 1'b0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (drop_push) begin
                overrun <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rx_irq <= 1'b0;
        end else begin
            rx_irq <= (count >= THRESH_CNT);
        end
    end

    // Storage is intentionally not reset; the read side is gated by rd_valid_o.
    always_ff @(posedge clk_i) begin
        if (do_push && !flush_i) begin
            mem[wr_ptr] <= s1_entry;
        end
    end

    logic [9:0] head;

    assign head       = mem[rd_ptr];
    assign rd_valid_o = ~fifo_empty;
    assign rd_data_o  = fifo_empty ? 8'h00 : head[7:0];
`ifdef UART_RX_DROP_ERR_FRAME_EN
    assign rd_perr_o  = 1'b0;
    assign rd_ferr_o  = 1'b0;
`else
    assign rd_perr_o  = ~fifo_empty & head[8];
    assign rd_ferr_o  = ~fifo_empty & head[9];
`endif
    assign count_o    = count;
    assign overrun_o  = overrun;
    assign rx_irq_o   = rx_irq;

endmodule

// File: doc/uart_rx_frame_decoder.md
# uart_rx_frame_decoder

Downstream stage of the UART receive path. Takes each raw 12-bit frame and its one-cycle completion pulse from the start-bit detector/shifter, then extracts the data bits. It checks parity and stop bits and buffers the results in a show-ahead FIFO. The CPU-side register interface reads decoded bytes and error status from this FIFO and receives a threshold interrupt.

## Interface
- DEPTH, 16, FIFO entries; power of two, 2..64
- RX_THRESH, 1, `rx_irq_o` asserts when occupancy >= RX_THRESH; range 1..DEPTH
- clk_i  in  1  clock
- rst_ni  in  1  reset, asynchronous, active-low
- frame_valid_i  in  1  one-cycle pulse: `frame_i` holds a complete frame
- frame_i  in  12  raw frame, bit0 = start bit, data LSB-first from bit1
- number_data_receive  in  4  data bits: 6, 7, 8; any other value = 5
- parity_bit_mode  in  1  parity bit present
- parity_odd_i  in  1  1 = odd parity, 0 = even
- stop_bit_twice  in  1  two stop bits
- flush_i  in  1  synchronous FIFO clear, also clears sticky flags
- rd_en_i  in  1  pop head entry
- rd_data_o  out  8  head data, zero-extended above N bits
- rd_perr_o  out  1  head entry parity error
- rd_ferr_o  out  1  head entry framing error
- rd_valid_o  out  1  FIFO non-empty
- count_o  out  $clog2(DEPTH)+1  occupancy
- overrun_o  out  1  sticky: frame lost because FIFO full
- rx_irq_o  out  1  registered, count_o >= RX_THRESH

## Operation
- Frame layout with N data bits:
  - bit0 = start, which is ignored.
  - bits[N:1] = data.
  - If parity is enabled: bit N+1 = parity, then the stop bit(s).
  - If parity is disabled: stop bit(s) start at bit N+1.
- Configuration inputs are sampled in the `frame_valid_i` cycle only.
- Parity check: XOR of the data bits XOR the parity bit must equal `parity_odd_i`; otherwise perr = 1. perr = 0 when parity is disabled.
- Framing check: ferr = 1 if any stop bit is 0. With `stop_bit_twice`, both stop bits are checked.
- Frame bits above the last stop bit are ignored.
- Two stages:
  - Stage 1 registers {ferr, perr, data} plus a valid bit.
  - Stage 2 writes this entry into the FIFO, which has 10-bit entries.
- Push/pop rules:
  - Pop is ignored when empty.
  - Push when full is dropped and sets `overrun_o`, unless `rd_en_i` is also asserted in that cycle; then both the push and the pop occur.
  - Simultaneous push and pop leaves `count_o` unchanged.
- Pointers are DEPTH-modulo and wrap naturally; full = count == DEPTH.
- `flush_i`:
  - Resets the pointers, count and stage 1 valid.
  - Clears `overrun_o`.
  - Has priority over a push or pop in the same cycle.
- Reset values:
  - All outputs are 0; the FIFO is empty.
  - FIFO storage need not be reset.
  - Reset mid-frame discards the stage 1 contents.

## Timing
- `frame_valid_i` high in cycle t gives the stage 1 register at the t edge and the FIFO write at the t+1 edge. `rd_valid_o`, `count_o` and the head data update in cycle t+2.
- Back-to-back `frame_valid_i` pulses every cycle are accepted at full throughput.
- `rd_data_o`/`rd_perr_o`/`rd_ferr_o` are show-ahead: valid combinationally from the head whenever `rd_valid_o` = 1. Pop takes effect at the clock edge.
- `rx_irq_o` is updated one cycle after `count_o` changes.
- `overrun_o` sets in the cycle after the dropped write.

## Configuration
- Macro: `UART_RX_DROP_ERR_FRAME_EN`.
- Defined:
  - Frames with perr or ferr are not written to the FIFO.
  - `rd_perr_o`/`rd_ferr_o` are tied 0.
  - A dropped error frame never sets `overrun_o`.
- Undefined: every frame is written, with its error flags stored per entry.

## Test plan
- 8N1, `frame_i` = 0x34A, pulse at t: `rd_valid_o` = 1 at t+2, `rd_data_o` = 0xA5, perr = 0, ferr = 0, `count_o` = 1. Pop brings count to 0.
- 8E1 (`parity_odd_i` = 0): `frame_i` = 0x4B4 gives data 0x5A with no error. `frame_i` = 0x6B4 gives perr = 1 (macro undefined), or no FIFO entry at all (macro defined).
- 8N1, `frame_i` = 0x14A (stop bit = 0): ferr = 1, data 0xA5.
- 5-bit data (`number_data_receive` = 4'd3), `frame_i` = 0xFFF: `rd_data_o` = 0x1F, no errors.
- Push DEPTH+1 frames without reads: `count_o` = DEPTH and `overrun_o` = 1. Then push with simultaneous `rd_en_i`: count stays DEPTH and `overrun_o` does not set again. Then `flush_i`: count = 0 and `overrun_o` = 0.
- RX_THRESH = 2: one frame gives `rx_irq_o` = 0; a second frame gives `rx_irq_o` = 1 one cycle after count = 2. Assert `rst_ni` low mid-stream: all outputs are 0 immediately.
